// File: rtl/jtag_pkg.sv
// Shared definitions for the boundary-scan wrapper.
// Contents: TAP state encoding, instruction opcodes, the IDCODE register
// width, and the helper that maps an opcode onto the data register it
// selects.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PDR   = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDR  = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PIR   = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPIR  = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    localparam int unsigned OP_EXTEST = 0;
    localparam int unsigned OP_SAMPLE = 1;
    localparam int unsigned OP_IDCODE = 2;
    localparam int unsigned OP_INTEST = 3;

    localparam int ID_W = 32;

    typedef enum logic [1:0] {
        DR_BSR = 2'd0,
        DR_ID  = 2'd1,
        DR_BYP = 2'd2
    } dr_sel_e;

    // BYPASS (all ones) and every undefined code fall through to the bypass cell.
    function automatic dr_sel_e dr_select(input logic [31:0] op);
        dr_sel_e sel;
        case (op)
            OP_EXTEST, OP_SAMPLE, OP_INTEST: sel = DR_BSR;
            OP_IDCODE:                       sel = DR_ID;
            default:                         sel = DR_BYP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller.
// Ports:
//   TCK, TRST (synchronous, active high), TMS  - controller inputs
//   state_o                                    - current TAP state
//   capture_*/shift_*/update_*_o, reset_tl_o   - high while in that state
// The strobes are registered alongside the state, so each is high for
// exactly the cycle in which the controller sits in the matching state.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e state_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o,
    output logic       reset_tl_o
);

    tap_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:   state_d = TMS ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   state_d = TMS ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: state_d = TMS ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: state_d = TMS ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  state_d = TMS ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: state_d = TMS ? TAP_UPDR  : TAP_PDR;
            TAP_PDR:   state_d = TMS ? TAP_EX2DR : TAP_PDR;
            TAP_EX2DR: state_d = TMS ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  state_d = TMS ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: state_d = TMS ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: state_d = TMS ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  state_d = TMS ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: state_d = TMS ? TAP_UPIR  : TAP_PIR;
            TAP_PIR:   state_d = TMS ? TAP_EX2IR : TAP_PIR;
            TAP_EX2IR: state_d = TMS ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  state_d = TMS ? TAP_SELDR : TAP_RTI;
            default:   state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q      <= TAP_TLR;
            capture_dr_o <= 1'b0;
            shift_dr_o   <= 1'b0;
            update_dr_o  <= 1'b0;
            capture_ir_o <= 1'b0;
            shift_ir_o   <= 1'b0;
            update_ir_o  <= 1'b0;
            reset_tl_o   <= 1'b1;
        end else begin
            state_q      <= state_d;
            capture_dr_o <= (state_d == TAP_CAPDR);
            shift_dr_o   <= (state_d == TAP_SHDR);
            update_dr_o  <= (state_d == TAP_UPDR);
            capture_ir_o <= (state_d == TAP_CAPIR);
            shift_ir_o   <= (state_d == TAP_SHIR);
            update_ir_o  <= (state_d == TAP_UPIR);
            reset_tl_o   <= (state_d == TAP_TLR);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_bscan_wrapper.sv
// Boundary-scan wrapper: TAP, instruction register, bypass, IDCODE and
// boundary register around a core with N_IN inputs and N_OUT outputs.
// Ports:
//   TCK, TRST, TMS, TDI, TDO, TDO_EN - test access port (TRST sync, active high)
//   pin_in   -> core_in   input boundary cells (INTEST drives core_in)
//   core_out -> pin_out   output boundary cells (EXTEST drives pin_out)
//   tap_state             current TAP state for debug
// BSR bit g is chain position g: bit 0 sits next to TDI, bit L-1 feeds TDO.
// Bits [N_IN-1:0] are the input cells, [L-1:N_IN] the output cells.
module jtag_bscan_wrapper
    import jtag_pkg::*;
#(
    parameter int          N_IN       = 4,
    parameter int          N_OUT      = 2,
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h0A5B_C0D1
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    input  logic [N_IN-1:0]  pin_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pin_out,
    output logic [3:0]       tap_state
);

    localparam int L = N_IN + N_OUT;

    tap_state_e tap_st;
    logic capture_dr, shift_dr, update_dr;
    logic capture_ir, shift_ir, update_ir, reset_tl;

    jtag_tap_fsm u_tap (
        .TCK          (TCK),
        .TRST         (TRST),
        .TMS          (TMS),
        .state_o      (tap_st),
        .capture_dr_o (capture_dr),
        .shift_dr_o   (shift_dr),
        .update_dr_o  (update_dr),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir),
        .reset_tl_o   (reset_tl)
    );

    // TRST and a cycle spent in Test-Logic-Reset clear the same state.
    logic clr;
    assign clr = TRST | reset_tl;

    logic [IR_W-1:0] ir_sr_q, ir_q;
    logic [ID_W-1:0] id_q;
    logic            byp_q;
    logic [L-1:0]    bsr_q, bsr_d, upd_q;
    logic [L-1:0]    cap_vec;
    dr_sel_e         dr_sel;
    logic            bsr_sel;

    assign dr_sel  = dr_select(32'(ir_q));
    assign bsr_sel = (dr_sel == DR_BSR);
    assign cap_vec = {core_out, pin_in};

    always_ff @(posedge TCK) begin
        if (clr) begin
            ir_sr_q <= '0;
            ir_q    <= IR_W'(OP_IDCODE);
        end else begin
            if (capture_ir) begin
                ir_sr_q <= IR_W'(1);
            end else if (shift_ir) begin
                ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};
            end
            if (update_ir) begin
                ir_q <= ir_sr_q;
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (clr) begin
            id_q  <= '0;
            byp_q <= 1'b0;
        end else begin
            if (capture_dr && dr_sel == DR_ID) begin
                id_q <= IDCODE_VAL;
            end else if (shift_dr && dr_sel == DR_ID) begin
                id_q <= {TDI, id_q[ID_W-1:1]};
            end
            if (capture_dr && dr_sel == DR_BYP) begin
                byp_q <= 1'b0;
            end else if (shift_dr && dr_sel == DR_BYP) begin
                byp_q <= TDI;
            end
        end
    end

    // Per-cell next value: capture source or the predecessor in the chain.
    for (genvar g = 0; g < L; g++) begin : g_cell
        if (g == 0) begin : g_first
            assign bsr_d[g] = capture_dr ? cap_vec[g] : TDI;
        end else begin : g_rest
            assign bsr_d[g] = capture_dr ? cap_vec[g] : bsr_q[g-1];
        end
    end

    always_ff @(posedge TCK) begin
        if (clr) begin
            bsr_q <= '0;
            upd_q <= '0;
        end else begin
            if (bsr_sel && (capture_dr || shift_dr)) begin
                bsr_q <= bsr_d;
            end
            if (bsr_sel && update_dr) begin
                upd_q <= bsr_q;
            end
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (shift_ir) begin
            TDO = ir_sr_q[0];
        end else if (shift_dr) begin
            case (dr_sel)
                DR_BSR:  TDO = bsr_q[L-1];
                DR_ID:   TDO = id_q[0];
                default: TDO = byp_q;
            endcase
        end
    end

    assign TDO_EN    = shift_ir | shift_dr;
    assign core_in   = (ir_q == IR_W'(OP_INTEST)) ? upd_q[N_IN-1:0] : pin_in;
    assign pin_out   = (ir_q == IR_W'(OP_EXTEST)) ? upd_q[L-1:N_IN] : core_out;
    assign tap_state = tap_st;

endmodule

// File: doc/jtag_bscan_wrapper.md
Name: jtag_bscan_wrapper

Overview:
Parametrised IEEE 1149.1 boundary-scan wrapper with its own TAP controller, instruction register, bypass, IDCODE and boundary register. It wraps a core with N_IN inputs and N_OUT outputs. Pins are on one side and the core on the other, and all test access is through TMS/TDI/TDO. It replaces the hand-wired, fixed-width scan wrapper with externally driven ShiftDR/ClockDR/UpdateDR/Mode controls.

Parameters:
N_IN, 4, number of core inputs (input boundary cells), >=1
N_OUT, 2, number of core outputs (output boundary cells), >=1
IR_W, 4, instruction register width, >=2
IDCODE_VAL, 32'h0A5B_C0D1, device ID; bit0 must be 1

Ports:
TCK  input  1  test clock; all state changes on rising edge
TRST  input  1  synchronous, active-high reset, sampled on rising TCK
TMS  input  1  TAP mode select
TDI  input  1  serial data in
TDO  output  1  serial data out
TDO_EN  output  1  1 while in Shift-IR or Shift-DR
pin_in  input  N_IN  device input pins
core_in  output  N_IN  to core inputs
core_out  input  N_OUT  from core outputs
pin_out  output  N_OUT  device output pins
tap_state  output  4  current TAP state, for debug

Behaviour:
- TAP FSM: standard 16-state 1149.1 graph, advanced by TMS on rising TCK. Encoding is in the package.
- TRST=1 at a TCK edge forces Test-Logic-Reset (TLR) and takes priority over TMS. Five TMS=1 edges from any state also reach TLR.
- In TLR: IR=IDCODE, update registers=0, bypass=0.
- Actions happen on the rising edge while the FSM is in the named state:
  - Capture-IR: IR shift register loads {(IR_W-2)'b0,2'b01}.
  - Shift-IR: IR shift register shifts right; TDI enters at MSB.
  - Update-IR: active IR loads from the shift register; new mode is effective from the next cycle.
  - Capture-DR, Shift-DR and Update-DR act on the DR selected by the active IR.
- Opcodes:
  - EXTEST = 0
  - SAMPLE_PRELOAD = 1
  - IDCODE = 2
  - INTEST = 3
  - BYPASS = all ones
  - Any undefined code behaves as BYPASS.
- DR selection:
  - BSR (boundary register) for EXTEST, SAMPLE_PRELOAD and INTEST.
  - 32-bit ID register for IDCODE.
  - 1-bit bypass register otherwise.
- BSR: L = N_IN + N_OUT cells.
  - Chain order: TDI→in[0]…in[N_IN-1]→out[0]…out[N_OUT-1]→TDO.
  - Capture: input cells take pin_in; output cells take core_out.
  - Shift: each cell takes its predecessor's value.
  - Update: the parallel update latch loads from the shift cells. It updates only when the BSR is selected; otherwise it holds.
- IDCODE register: capture loads IDCODE_VAL. Shifts LSB first toward TDO.
- Bypass register: capture loads 0. In Shift-DR, TDI is delayed one TCK.
- TDO:
  - Combinational: LSB of the IR shift register in Shift-IR, or the last cell of the selected DR in Shift-DR.
  - Forced to 0 in all other states. TDO_EN matches.
- Muxing:
  - core_in = update_in when IR==INTEST, else pin_in.
  - pin_out = update_out when IR==EXTEST, else core_out.
  - Both are combinational from the registered IR and update latches.
- Reset values:
  - TDO=0, TDO_EN=0, tap_state=TLR.
  - core_in=pin_in and pin_out=core_out (functional passthrough).
- TRST mid-shift: shift contents are discarded and update latches cleared. Output pins revert to passthrough on the next cycle.
- An IR change away from EXTEST or INTEST restores passthrough immediately after Update-IR. Update latches retain their values.

Decomposition:
- Package jtag_pkg:
  - TAP state encoding (4-bit localparams for the 16 states)
  - Opcode localparams
  - IDCODE width constant (32)
- Sub-module jtag_tap_fsm: inputs TCK, TRST, TMS; outputs state plus decoded strobes capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, reset_tl.
- The top level holds the IR, the DRs, the BSR chain (generate loop) and the muxes.

Test Plan:
- TRST=1 for 1 TCK, then TMS=0 → tap_state=Run-Test/Idle; IR=IDCODE; pin_out==core_out; core_in==pin_in. Repeat using TMS=1 ×5 from Shift-DR → TLR.
- From reset, go to Shift-DR and shift 32 bits → TDO stream LSB-first equals 32'h0A5B_C0D1; TDO_EN=1 only during Shift-DR.
- Load IR=4'b1111; Shift-IR capture shifts out 4'b0001 (LSB first: 1,0,0,0). Then Shift-DR with TDI=1,0,1,1 → TDO=0,1,0,1 (one-cycle delay). Undefined opcode 4'b0111 gives the same result.
- SAMPLE_PRELOAD with pin_in=4'b1010 and core_out=2'b01, 6 shifts → TDO order out[1],out[0],in[3..0] = 0,1,1,0,1,0; pins stay passthrough.
- Preload BSR out cells with 2'b10, then EXTEST → after Update-IR pin_out=2'b10 regardless of core_out. INTEST with in cells loaded 4'b0110 → core_in=4'b0110 while pin_in=4'b1111.
- In EXTEST, assert TRST during Shift-DR → next cycle tap_state=TLR, pin_out=core_out, TDO_EN=0.
